// File: rtl/div_ctrl_pkg.sv
// div_ctrl_pkg: shared state codes, handshake levels and widths for the EX-stage divider.
package div_ctrl_pkg;
  localparam int RegBus = 32;
  typedef enum logic [1:0] {
    DivFree   = 2'b00,
    DivByZero = 2'b01,
    DivOn     = 2'b10,
    DivEnd    = 2'b11
  } div_state_e;
  localparam logic DivResultReady    = 1'b1;
  localparam logic DivResultNotReady = 1'b0;
  localparam logic DivStart          = 1'b1;
  localparam logic DivStop           = 1'b0;
  localparam logic DivAnnul          = 1'b1;
endpackage

// File: rtl/div_step.sv
// div_step: one radix-2 restoring iteration (shift {rem,quot} left, conditional subtract).
module div_step import div_ctrl_pkg::*; #(
  parameter int DATA_W = RegBus
) (
  input  logic [DATA_W-1:0] rem_i,
  input  logic [DATA_W-1:0] quot_i,
  input  logic [DATA_W-1:0] divisor_i,
  output logic [DATA_W-1:0] rem_o,
  output logic [DATA_W-1:0] quot_o
);
  // the shifted remainder can exceed DATA_W bits, so compare with one extra bit
  logic [DATA_W:0] rem_sh;
  logic            ge;
  assign rem_sh = {rem_i, quot_i[DATA_W-1]};
  assign ge     = rem_sh >= {1'b0, divisor_i};
  assign rem_o  = ge ? DATA_W'(rem_sh - {1'b0, divisor_i}) : rem_sh[DATA_W-1:0];
  assign quot_o = {quot_i[DATA_W-2:0], ge};
endmodule

// File: rtl/div_ctrl.sv
// div_ctrl: 32-cycle restoring DIV/DIVU sequencer for EX; result_o = {rem, quot}.
// Macro DIV_EARLY_EXIT_EN: finish at once when |dividend| < |divisor| (quot=0, rem=dividend).
module div_ctrl import div_ctrl_pkg::*; #(
  parameter int DATA_W = RegBus,
  parameter int CNT_W  = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                signed_div_i,
  input  logic [DATA_W-1:0]   opdata1_i,
  input  logic [DATA_W-1:0]   opdata2_i,
  input  logic                start_i,
  input  logic                annul_i,
  output logic [2*DATA_W-1:0] result_o,
  output logic                ready_o,
  output logic                stallreq_o
);
  div_state_e        state, nxt;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W-1:0] rem, quot, dvsr, rem_nxt, quot_nxt, abs_a, abs_b, fix_q, fix_r;
  logic              neg_q, neg_r, go, annul, early;
  assign go    = start_i == DivStart && annul_i != DivAnnul;
  assign annul = annul_i == DivAnnul;
  assign abs_a = signed_div_i && opdata1_i[DATA_W-1] ? -opdata1_i : opdata1_i;
  assign abs_b = signed_div_i && opdata2_i[DATA_W-1] ? -opdata2_i : opdata2_i;
  assign fix_q = neg_q ? -quot : quot;
  assign fix_r = neg_r ? -rem : rem;
`ifdef DIV_EARLY_EXIT_EN
  assign early = abs_a < abs_b;
`else
  assign early = 1'b0;
`endif
  div_step #(.DATA_W(DATA_W)) u_step (
    .rem_i    (rem),
    .quot_i   (quot),
    .divisor_i(dvsr),
    .rem_o    (rem_nxt),
    .quot_o   (quot_nxt)
  );
  always_ff @(posedge clk or negedge rst)
    if (!rst) state <= DivFree;
    else      state <= nxt;
  always_comb begin
    nxt = state;
    unique case (state)
      DivFree:   nxt = !go ? DivFree : opdata2_i == '0 ? DivByZero : early ? DivEnd : DivOn;
      DivByZero: nxt = annul ? DivFree : DivEnd;
      DivOn:     nxt = annul ? DivFree : cnt == CNT_W'(DATA_W - 1) ? DivEnd : DivOn;
      default:   nxt = go ? DivEnd : DivFree;
    endcase
  end
  always_comb stallreq_o = go && ready_o != DivResultReady;
  // ready_o/result_o are registered from DivEnd, so they rise one edge after entering it
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      rem      <= '0;
      quot     <= '0;
      dvsr     <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      cnt      <= '0;
      result_o <= '0;
      ready_o  <= DivResultNotReady;
    end else begin
      unique case (state)
        DivFree: begin
          cnt      <= '0;
          result_o <= '0;
          ready_o  <= DivResultNotReady;
          if (go) begin
            dvsr  <= abs_b;
            neg_q <= signed_div_i && (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
            neg_r <= signed_div_i && opdata1_i[DATA_W-1];
            rem   <= early ? abs_a : '0;
            quot  <= early ? '0 : abs_a;
          end
        end
        DivByZero: begin
          rem  <= '0;
          quot <= '0;
          cnt  <= '0;
        end
        DivOn: begin
          cnt <= annul ? '0 : cnt + 1'b1;
          if (!annul) begin
            rem  <= rem_nxt;
            quot <= quot_nxt;
          end
        end
        default: begin
          ready_o  <= go ? DivResultReady : DivResultNotReady;
          result_o <= go ? {fix_r, fix_q} : '0;
        end
      endcase
    end
endmodule

// File: tb/tb_div_ctrl.sv
// tb_div_ctrl: directed + random divides scored against an arithmetic reference model.
module tb_div_ctrl;
  logic        clk = 1'b0, rst = 1'b0, signed_div_i = 1'b0, start_i = 1'b0, annul_i = 1'b0;
  logic [31:0] opdata1_i = '0, opdata2_i = '0;
  logic [63:0] result_o;
  logic        ready_o, stallreq_o;
  int          cyc = 0, passed = 0, total = 0;
  logic        ready_q = 1'b0;
  typedef struct {logic [63:0] res; int at;} exp_t;
  exp_t sb[$];

  div_ctrl dut (
    .clk(clk), .rst(rst), .signed_div_i(signed_div_i), .opdata1_i(opdata1_i),
    .opdata2_i(opdata2_i), .start_i(start_i), .annul_i(annul_i),
    .result_o(result_o), .ready_o(ready_o), .stallreq_o(stallreq_o)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [31:0] mag(input logic [31:0] x, input logic s);
    return (s && x[31]) ? -x : x;
  endfunction

  function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic s);
    logic signed [31:0] sa, sbv;
    logic [31:0] q, r;
    if (b == 0) return 64'd0;
    if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, a};
    if (s) begin
      sa = a; sbv = b;
      q = sa / sbv; r = sa % sbv;
    end else begin
      q = a / b; r = a % b;
    end
    return {r, q};
  endfunction

  function automatic int lat(input logic [31:0] a, input logic [31:0] b, input logic s);
    if (b == 0) return 2;
`ifdef DIV_EARLY_EXIT_EN
    if (mag(a, s) < mag(b, s)) return 1;
`endif
    return 33;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (rst && ready_o && !ready_q) begin
      if (sb.size() == 0) check("unexpected_ready", 64'd1, 64'd0);
      else begin
        e = sb.pop_front();
        check("result", result_o, e.res);
        check("latency", 64'(cyc), 64'(e.at));
      end
    end
    ready_q <= ready_o;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic s, input bit push);
    opdata1_i = a; opdata2_i = b; signed_div_i = s; start_i = 1'b1;
    if (push) sb.push_back('{model(a, b, s), cyc + 1 + lat(a, b, s)});
    #1 check("stall_on_start", 64'(stallreq_o), 64'd1);
  endtask

  task automatic wait_ready;
    int n = 0;
    while (!ready_o && n < 40) begin
      tick;
      n++;
    end
    if (!ready_o) check("ready_timeout", 64'(ready_o), 64'd1);
  endtask

  task automatic release_start;
    check("stall_while_ready", 64'(stallreq_o), 64'd0);
    start_i = 1'b0;
    tick;
    check("ready_drop", {63'd0, ready_o}, 64'd0);
    check("result_clear", result_o, 64'd0);
  endtask

  task automatic do_op(input logic [31:0] a, input logic [31:0] b, input logic s);
    issue(a, b, s, 1'b1);
    wait_ready;
    release_start;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a, b;
    #12;
    check("reset_ready", 64'(ready_o), 64'd0);
    check("reset_result", result_o, 64'd0);
    check("reset_stall", 64'(stallreq_o), 64'd0);
    tick;
    rst = 1'b1;
    tick;
    do_op(32'd100, 32'd7, 1'b0);
    do_op(32'hFFFF_FFF9, 32'd2, 1'b1);
    do_op(32'hFFFF_FFF9, 32'd2, 1'b0);
    do_op(32'd5, 32'd0, 1'b0);
    do_op(32'h8000_0000, 32'hFFFF_FFFF, 1'b1);
    do_op(32'd3, 32'd10, 1'b0);
    do_op(32'hFFFF_FFF9, 32'd100, 1'b1);
    // annul mid-divide, then a new request follows directly
    issue(32'd100, 32'd7, 1'b0, 1'b0);
    repeat (10) tick;
    annul_i = 1'b1;
    #1 check("stall_annul", 64'(stallreq_o), 64'd0);
    tick;
    annul_i = 1'b0;
    do_op(32'd9, 32'd3, 1'b0);
    // async reset mid-divide
    issue(32'd100, 32'd7, 1'b0, 1'b0);
    repeat (20) tick;
    #2 rst = 1'b0;
    #1 check("rst_ready", 64'(ready_o), 64'd0);
    check("rst_result", result_o, 64'd0);
    start_i = 1'b0;
    tick;
    rst = 1'b1;
    tick;
    do_op(32'hFFFF_FFFF, 32'h10, 1'b0);
    // result held while start stays high, then async reset clears it at once
    issue(32'd100, 32'd7, 1'b0, 1'b1);
    wait_ready;
    repeat (3) tick;
    check("hold_ready", 64'(ready_o), 64'd1);
    check("hold_result", result_o, {32'd2, 32'd14});
    #2 rst = 1'b0;
    #1 check("rst_hold_ready", 64'(ready_o), 64'd0);
    check("rst_hold_result", result_o, 64'd0);
    start_i = 1'b0;
    tick;
    rst = 1'b1;
    tick;
    for (int i = 0; i < 40; i++) begin
      a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 50)) : $urandom;
      case ($urandom_range(0, 7))
        0:       b = 32'd0;
        1, 2, 3: b = 32'($urandom_range(1, 15));
        4:       b = 32'hFFFF_FFFF - 32'($urandom_range(0, 15));
        default: b = $urandom;
      endcase
      do_op(a, b, 1'($urandom_range(0, 1)));
    end
    tick;
    check("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
